// File: rtl/signed_or_unsigned_div_pkg.sv
// div_pkg: shared types for the sequential sign-magnitude divider.
package div_pkg;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction
endpackage

// File: rtl/signed_or_unsigned_div_twos_neg.sv
// twos_neg: conditional two's-complement negate, modulo 2^n.
module twos_neg #(
    parameter int n = 8
) (
    input  logic [n-1:0] in,
    input  logic         en,
    output logic [n-1:0] out
);
    assign out = en ? ~in + 1'b1 : in;
endmodule

// File: rtl/signed_or_unsigned_div.sv
// signed_or_unsigned_div: radix-2 restoring divider with runtime sign select and valid/ready.
module signed_or_unsigned_div
    import div_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         sign,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] quot,
    output logic [n-1:0] rem,
    output logic         div_by_zero
);
    localparam int CW = cnt_width(n);
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n-1:0] r_q, r_d, d_q, d_d, mb_q, mb_d, a_q, a_d, quot_q, quot_d, rem_q, rem_d;
    logic nq_q, nq_d, nr_q, nr_d, z_q, z_d, ov_q, ov_d, dz_q, dz_d;
    logic [n-1:0] ma, mb, qf, rf;
    logic [n:0] sh, diff;
    logic ge;
    twos_neg #(.n(n)) u_neg_a (.in(a), .en(sign & a[n-1]), .out(ma));
    twos_neg #(.n(n)) u_neg_b (.in(b), .en(sign & b[n-1]), .out(mb));
    twos_neg #(.n(n)) u_fix_q (.in(d_q), .en(nq_q), .out(qf));
    twos_neg #(.n(n)) u_fix_r (.in(r_q), .en(nr_q), .out(rf));
    assign in_ready    = state_q == IDLE;
    assign out_valid   = ov_q;
    assign quot        = quot_q;
    assign rem         = rem_q;
    assign div_by_zero = dz_q;
    // d_q holds the shifting dividend and collects quotient bits from the right
    always_comb begin
        sh      = {r_q, d_q[n-1]};
        diff    = sh - {1'b0, mb_q};
        ge      = sh >= {1'b0, mb_q};
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        d_d     = d_q;
        mb_d    = mb_q;
        a_d     = a_q;
        nq_d    = nq_q;
        nr_d    = nr_q;
        z_d     = z_q;
        ov_d    = ov_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                mb_d    = mb;
                d_d     = ma;
                r_d     = '0;
                nq_d    = sign & (a[n-1] ^ b[n-1]);
                nr_d    = sign & a[n-1];
                z_d     = b == '0;
                cnt_d   = CW'(n - 1);
                state_d = (b == '0) ? FIX : CALC;
            end
            CALC: begin
                r_d     = ge ? diff[n-1:0] : sh[n-1:0];
                d_d     = {d_q[n-2:0], ge};
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == '0) ? FIX : CALC;
            end
            FIX: begin
                quot_d  = z_q ? '1 : qf;
                rem_d   = z_q ? a_q : rf;
                dz_d    = z_q;
                ov_d    = 1'b1;
                state_d = DONE;
            end
            DONE: if (out_ready) begin
                ov_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            d_q     <= '0;
            mb_q    <= '0;
            a_q     <= '0;
            nq_q    <= 1'b0;
            nr_q    <= 1'b0;
            z_q     <= 1'b0;
            ov_q    <= 1'b0;
            dz_q    <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            d_q     <= d_d;
            mb_q    <= mb_d;
            a_q     <= a_d;
            nq_q    <= nq_d;
            nr_q    <= nr_d;
            z_q     <= z_d;
            ov_q    <= ov_d;
            dz_q    <= dz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end
endmodule

// File: tb/tb_signed_or_unsigned_div.sv
// tb_signed_or_unsigned_div: directed and exhaustive checks of the 4-bit divider.
module tb_signed_or_unsigned_div;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, sign = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, div_by_zero;
    logic [3:0] a = '0, b = '0, quot, rem;
    int checks = 0, errors = 0;

    signed_or_unsigned_div #(.n(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sign(sign), .out_valid(out_valid), .out_ready(out_ready),
        .quot(quot), .rem(rem), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // lat counts clock edges from the accept edge (inclusive) to the edge raising out_valid; 0 on timeout
    task automatic run_op(input logic [3:0] ia, ib, input logic is,
                          output logic [3:0] q, r, output logic z, output int lat);
        int k = 0;
        @(negedge clk);
        while (!in_ready && k < 20) begin @(negedge clk); k++; end
        a = ia; b = ib; sign = is; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a = ~ia; b = ~ib; sign = ~is;
        lat = 1;
        while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
        if (!out_valid) lat = 0;
        q = quot; r = rem; z = div_by_zero;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (quot !== 4'h0 || rem !== 4'h0) begin errors++; $display("FAIL reset_result got q=%h r=%h want 0 0", quot, rem); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        logic [3:0] q, r; logic z; int lat;
        run_op(4'd13, 4'd3, 1'b0, q, r, z, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL unsigned_latency got %0d want 6", lat); end
        checks++; if (q !== 4'd4 || r !== 4'd1 || z !== 1'b0) begin errors++; $display("FAIL unsigned_13_3 got q=%h r=%h z=%b want 4 1 0", q, r, z); end
        run_op(4'd15, 4'd15, 1'b0, q, r, z, lat);
        checks++; if (q !== 4'd1 || r !== 4'd0) begin errors++; $display("FAIL unsigned_15_15 got q=%h r=%h want 1 0", q, r); end
    endtask

    task automatic test_signed();
        logic [3:0] q, r; logic z; int lat;
        run_op(4'b1001, 4'b0010, 1'b1, q, r, z, lat);
        checks++; if (q !== 4'b1101 || r !== 4'b1111 || z !== 1'b0) begin errors++; $display("FAIL signed_m7_2 got q=%h r=%h z=%b want d f 0", q, r, z); end
        run_op(4'b0111, 4'b1110, 1'b1, q, r, z, lat);
        checks++; if (q !== 4'b1101 || r !== 4'b0001) begin errors++; $display("FAIL signed_7_m2 got q=%h r=%h want d 1", q, r); end
    endtask

    task automatic test_div_zero();
        logic [3:0] q, r; logic z; int lat;
        run_op(4'd5, 4'd0, 1'b0, q, r, z, lat);
        checks++; if (q !== 4'hF || r !== 4'h5 || z !== 1'b1) begin errors++; $display("FAIL dbz_unsigned got q=%h r=%h z=%b want f 5 1", q, r, z); end
        run_op(4'd5, 4'd0, 1'b1, q, r, z, lat);
        checks++; if (q !== 4'hF || r !== 4'h5 || z !== 1'b1) begin errors++; $display("FAIL dbz_signed got q=%h r=%h z=%b want f 5 1", q, r, z); end
        run_op(4'd6, 4'd3, 1'b0, q, r, z, lat);
        checks++; if (q !== 4'd2 || r !== 4'd0 || z !== 1'b0) begin errors++; $display("FAIL dbz_clear got q=%h r=%h z=%b want 2 0 0", q, r, z); end
    endtask

    task automatic test_overflow();
        logic [3:0] q, r; logic z; int lat;
        run_op(4'h8, 4'hF, 1'b1, q, r, z, lat);
        checks++; if (q !== 4'h8 || r !== 4'h0 || z !== 1'b0) begin errors++; $display("FAIL overflow got q=%h r=%h z=%b want 8 0 0", q, r, z); end
    endtask

    task automatic test_backpressure();
        int k = 0;
        logic seen = 1'b0;
        @(negedge clk);
        a = 4'd7; b = 4'd2; sign = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && k < 20) begin @(negedge clk); k++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout got out_valid=%b want 1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin in_valid = 1'b1; a = 4'd1; b = 4'd1; end
            @(negedge clk);
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ctrl got ov=%b ir=%b want 1 0", out_valid, in_ready); end
            checks++; if (quot !== 4'd3 || rem !== 4'd1) begin errors++; $display("FAIL bp_hold_data got q=%h r=%h want 3 1", quot, rem); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got ir=%b ov=%b want 1 0", in_ready, out_valid); end
        for (int i = 0; i < 8; i++) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL bp_no_second_op got out_valid seen=%b want 0", seen); end
    endtask

    task automatic test_reset_mid_op();
        logic [3:0] q, r; logic z; int lat;
        @(negedge clk);
        a = 4'd13; b = 4'd3; sign = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got ir=%b ov=%b want 1 0", in_ready, out_valid); end
        checks++; if (quot !== 4'h0 || rem !== 4'h0) begin errors++; $display("FAIL midrst_data got q=%h r=%h want 0 0", quot, rem); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        run_op(4'd14, 4'd4, 1'b0, q, r, z, lat);
        checks++; if (q !== 4'd3 || r !== 4'd2 || lat !== 6) begin errors++; $display("FAIL midrst_next got q=%h r=%h lat=%0d want 3 2 6", q, r, lat); end
    endtask

    task automatic test_sweep();
        logic [3:0] q, r, eq, er; logic z; int lat, ia, ib, el;
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++) begin
                    run_op(4'(x), 4'(y), s[0], q, r, z, lat);
                    ia = (s == 1 && x > 7) ? x - 16 : x;
                    ib = (s == 1 && y > 7) ? y - 16 : y;
                    eq = (y == 0) ? 4'hF : 4'(ia / ib);
                    er = (y == 0) ? 4'(x) : 4'(ia % ib);
                    el = (y == 0) ? 2 : 6;
                    checks++;
                    if (q !== eq || r !== er || z !== (y == 0) || lat !== el) begin
                        errors++;
                        $display("FAIL sweep s=%0d a=%h b=%h got q=%h r=%h z=%b lat=%0d want %h %h %b %0d", s, x[3:0], y[3:0], q, r, z, lat, eq, er, y == 0, el);
                    end
                end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_reset_mid_op();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
